instruction_fetch: RTL and testbench

- Instruction Fetch (IF) stage of the 5-stage RV32I pipeline, directly upstream of the decode stage.
- Owns the PC and drives the IF/ID register (valid, pc, ir) consumed by decode.
- Issues at most one outstanding request to instruction memory over a valid/ready request channel and a valid-only response channel.
- Honours stall (pc_write, ifid_write), flush, and branch/jump redirects from later stages.

---
 rtl/instruction_fetch.sv | 212 +++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 546 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Instruction Fetch stage of a 5-stage RV32I pipeline. Owns the program
// counter, issues at most one outstanding fetch to instruction memory, and
// drives the IF/ID pipeline register consumed by decode.
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   pc_write         in   0 = freeze PC, issue no new request
//   ifid_write       in   0 = hold IF/ID contents
//   flush            in   load a bubble into IF/ID this cycle
//   redirect_valid   in   taken branch/jump resolved downstream
//   redirect_pc      in   redirect target (low two bits reported, then dropped)
//   imem_req_valid   out  fetch request valid
//   imem_req_ready   in   memory accepts the request
//   imem_req_addr    out  word-aligned fetch address
//   imem_resp_valid  in   response data valid (no backpressure)
//   imem_resp_data   in   fetched instruction word
//   ifid_valid       out  IF/ID holds a real instruction
//   ifid_pc          out  PC of ifid_ir
//   ifid_ir          out  instruction presented to decode
//   fetch_misaligned out  one-cycle pulse after a redirect to a misaligned PC
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_ir,
    output logic        fetch_misaligned
);

    // FETCH: idle, may issue a request
    // WAIT : one request outstanding, response will be used
    // HOLD : response captured in the buffer, waiting for IF/ID to open
    // DROP : one request outstanding, response will be discarded
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_buf_ir;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_ir;
    logic        r_misaligned;

    logic [1:0]  w_next_state;
    logic [31:0] w_next_pc;
    logic [31:0] w_redirect_aligned;
    logic        w_req_fire;
    logic        w_deliver;
    logic [31:0] w_deliver_ir;
    logic        w_buf_load;

    assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};

    // A redirect in the same cycle suppresses the request so the stale
    // sequential PC is never fetched.
    assign imem_req_valid = (r_state == S_FETCH) & pc_write & ~redirect_valid;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    // -------------------------------------------------------------------------
    // Next-state / next-PC logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a signal unassigned and infer a latch.
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_deliver    = 1'b0;
        w_deliver_ir = imem_resp_data;
        w_buf_load   = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (redirect_valid) begin
                    w_next_pc = w_redirect_aligned;
                end else if (w_req_fire) begin
                    w_next_pc    = r_pc + 32'd4;
                    w_next_state = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    w_next_pc = w_redirect_aligned;
                    // If the response is here now it is simply dropped;
                    // otherwise it is still in flight and must be absorbed.
                    w_next_state = imem_resp_valid ? S_FETCH : S_DROP;
                end else if (imem_resp_valid) begin
                    if (ifid_write) begin
                        w_deliver    = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_buf_load   = 1'b1;
                        w_next_state = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                w_deliver_ir = r_buf_ir;
                if (redirect_valid) begin
                    w_next_pc    = w_redirect_aligned;
                    w_next_state = S_FETCH;
                end else if (ifid_write) begin
                    w_deliver    = 1'b1;
                    w_next_state = S_FETCH;
                end
            end

            S_DROP: begin
                // The newest redirect target always wins; the in-flight
                // response is discarded whenever it shows up.
                if (redirect_valid) begin
                    w_next_pc = w_redirect_aligned;
                end
                if (imem_resp_valid) begin
                    w_next_state = S_FETCH;
                end
            end

            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!reset) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_next_pc;
            // Every redirect is accepted in every state, so the pulse only
            // depends on the redirect itself.
            r_misaligned <= redirect_valid & (|redirect_pc[1:0]);
        end
    end

    // -------------------------------------------------------------------------
    // Request PC and one-entry response buffer
    // -------------------------------------------------------------------------
    // NOTE: these payload registers have no reset; they are only read in
    // states (WAIT/HOLD) that are reachable solely after they were written.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_req_pc <= r_pc;
        end
        if (w_buf_load) begin
            r_buf_ir <= imem_resp_data;
        end
    end

    // -------------------------------------------------------------------------
    // IF/ID register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'h0000_0000;
            r_ifid_ir    <= NOP_INSTR;
        end else if (flush) begin
            // Flush beats everything, including a delivery this cycle; the
            // PC is left alone since a bubble's PC is never consumed.
            r_ifid_valid <= 1'b0;
            r_ifid_ir    <= NOP_INSTR;
        end else if (ifid_write) begin
            if (w_deliver) begin
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= r_req_pc;
                r_ifid_ir    <= w_deliver_ir;
            end else begin
                r_ifid_valid <= 1'b0;
                r_ifid_ir    <= NOP_INSTR;
            end
        end
    end

    assign ifid_valid       = r_ifid_valid;
    assign ifid_pc          = r_ifid_pc;
    assign ifid_ir          = r_ifid_ir;
    assign fetch_misaligned = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. An instruction memory model
// answers each accepted request after a configurable latency with
// data = addr ^ 32'hA5A5_A5A5. Directed scenarios are followed by a random
// run scored against a transaction-level model (expected fetch address
// stream plus a queue of fetched-but-not-yet-consumed addresses).
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        ifid_write;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_ir;
    logic        fetch_misaligned;

    int tests_run    = 0;
    int tests_failed = 0;

    // memory model state
    bit          mem_pend;
    int          mem_dly;
    int          mem_lat;
    logic [31:0] mem_addr;
    bit          acc;
    logic [31:0] acc_addr;
    bit          proto_err;

    instruction_fetch #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .ifid_valid       (ifid_valid),
        .ifid_pc          (ifid_pc),
        .ifid_ir          (ifid_ir),
        .fetch_misaligned (fetch_misaligned)
    );

    initial forever #5 clk = ~clk;

    // Advance one cycle: note any handshake, cross the rising edge, then on
    // the falling edge drive the memory response for the new cycle.
    task automatic tick();
        #1;
        acc      = imem_req_valid & imem_req_ready;
        acc_addr = imem_req_addr;
        @(posedge clk);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (acc) begin
            if (mem_pend) proto_err = 1'b1;
            mem_pend = 1'b1;
            mem_dly  = mem_lat;
            mem_addr = acc_addr;
        end
        if (mem_pend) begin
            mem_dly--;
            if (mem_dly == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_addr ^ KEY;
                mem_pend        = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        pc_write        = 1'b0;
        ifid_write      = 1'b0;
        flush           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        mem_pend        = 1'b0;
        mem_lat         = 1;
        proto_err       = 1'b0;
        reset           = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Reset, then run n cycles of plain sequential fetching.
    task automatic startup(input int n);
        do_reset();
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        reset    = 1'b0;
        pc_write = 1'b1;
        #1;
        tests_run++;
        if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_ir !== NOP || fetch_misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ifid: got v=%b pc=%h ir=%h mis=%b, expected v=0 pc=0 ir=%h mis=0",
                     ifid_valid, ifid_pc, ifid_ir, fetch_misaligned, NOP);
        end
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL reset_req: got valid=%b addr=%h, expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        startup(0);
        for (int k = 0; k < 3; k++) begin
            a = 32'(4 * k);
            #1;
            tests_run++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin
                tests_failed++;
                $display("FAIL seq_req%0d: got valid=%b addr=%h, expected 1 %h", k, imem_req_valid, imem_req_addr, a);
            end
            if (k > 0) begin
                tests_run++;
                if (ifid_valid !== 1'b1 || ifid_pc !== a - 32'd4 || ifid_ir !== ((a - 32'd4) ^ KEY)) begin
                    tests_failed++;
                    $display("FAIL seq_ifid%0d: got v=%b pc=%h ir=%h, expected 1 %h %h",
                             k, ifid_valid, ifid_pc, ifid_ir, a - 32'd4, (a - 32'd4) ^ KEY);
                end
            end
            tick();
            tests_run++;
            if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL seq_gap%0d: got req_valid=%b ifid_valid=%b, expected 0 0", k, imem_req_valid, ifid_valid);
            end
            tick();
        end
        tests_run++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8 || ifid_ir !== (32'h8 ^ KEY)) begin
            tests_failed++;
            $display("FAIL seq_last: got v=%b pc=%h ir=%h, expected 1 00000008 %h", ifid_valid, ifid_pc, ifid_ir, 32'h8 ^ KEY);
        end
    endtask

    task automatic test_hold_buffer();
        startup(4);              // cycle 4: IF/ID = 0x4, request 0x8 going out
        ifid_write = 1'b0;
        for (int c = 4; c < 7; c++) begin
            tick();              // response for 0x8 lands in cycle 5
            tests_run++;
            if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin
                tests_failed++;
                $display("FAIL hold_ifid_c%0d: got v=%b pc=%h, expected 1 00000004", c + 1, ifid_valid, ifid_pc);
            end
            if (c > 4) begin
                tests_run++;
                if (imem_req_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL hold_noreq_c%0d: got req_valid=%b, expected 0", c + 1, imem_req_valid);
                end
            end
        end
        ifid_write = 1'b1;
        tick();
        #1;
        tests_run++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8 || ifid_ir !== (32'h8 ^ KEY)) begin
            tests_failed++;
            $display("FAIL hold_release: got v=%b pc=%h ir=%h, expected 1 00000008 %h", ifid_valid, ifid_pc, ifid_ir, 32'h8 ^ KEY);
        end
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin
            tests_failed++;
            $display("FAIL hold_next_req: got valid=%b addr=%h, expected 1 0000000c", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        startup(6);              // cycle 6: request 0xC going out
        mem_lat = 3;
        tick();                  // cycle 7: 0xC outstanding
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        for (int c = 8; c < 10; c++) begin
            tests_run++;
            if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL redir_drop_c%0d: got req_valid=%b ifid_valid=%b, expected 0 0", c, imem_req_valid, ifid_valid);
            end
            tick();
        end
        mem_lat = 1;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || ifid_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_req: got valid=%b addr=%h ifid_valid=%b, expected 1 00000100 0",
                     imem_req_valid, imem_req_addr, ifid_valid);
        end
        tick();
        tick();
        tests_run++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100 || ifid_ir !== (32'h100 ^ KEY)) begin
            tests_failed++;
            $display("FAIL redir_ifid: got v=%b pc=%h ir=%h, expected 1 00000100 %h", ifid_valid, ifid_pc, ifid_ir, 32'h100 ^ KEY);
        end
    endtask

    task automatic test_misaligned();
        startup(0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_suppress: got req_valid=%b, expected 0", imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            tests_failed++;
            $display("FAIL mis_pulse: got mis=%b valid=%b addr=%h, expected 1 1 00000200", fetch_misaligned, imem_req_valid, imem_req_addr);
        end
        tick();                  // response for 0x200 arrives; redirect beats it
        tests_run++;
        if (fetch_misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_width: got mis=%b, expected 0", fetch_misaligned);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300 || ifid_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_aligned_redir: got mis=%b valid=%b addr=%h ifid_valid=%b, expected 0 1 00000300 0",
                     fetch_misaligned, imem_req_valid, imem_req_addr, ifid_valid);
        end
    endtask

    task automatic test_wrap_and_freeze();
        startup(0);
        pc_write       = 1'b0;   // a redirect must still be taken while frozen
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b0 || fetch_misaligned !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_frozen: got valid=%b mis=%b, expected 0 1", imem_req_valid, fetch_misaligned);
        end
        pc_write = 1'b1;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_req: got valid=%b addr=%h, expected 1 fffffffc", imem_req_valid, imem_req_addr);
        end
        tick();
        tick();
        #1;
        tests_run++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'hFFFF_FFFC || ifid_ir !== (32'hFFFF_FFFC ^ KEY)
            || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_next: got v=%b pc=%h ir=%h req=%b addr=%h, expected 1 fffffffc %h 1 00000000",
                     ifid_valid, ifid_pc, ifid_ir, imem_req_valid, imem_req_addr, 32'hFFFF_FFFC ^ KEY);
        end
    endtask

    task automatic test_flush();
        startup(0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        tick();                  // response for 0x10 present this cycle
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        tests_run++;
        if (ifid_valid !== 1'b0 || ifid_ir !== NOP || ifid_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL flush_bubble: got v=%b pc=%h ir=%h, expected 0 00000000 %h", ifid_valid, ifid_pc, ifid_ir, NOP);
        end
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h14) begin
            tests_failed++;
            $display("FAIL flush_next_req: got valid=%b addr=%h, expected 1 00000014", imem_req_valid, imem_req_addr);
        end
        tick();
        tests_run++;
        if (ifid_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_0x10: got v=%b pc=%h, expected 0", ifid_valid, ifid_pc);
        end
        tick();
        tests_run++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h14 || ifid_ir !== (32'h14 ^ KEY)) begin
            tests_failed++;
            $display("FAIL flush_after: got v=%b pc=%h ir=%h, expected 1 00000014 %h", ifid_valid, ifid_pc, ifid_ir, 32'h14 ^ KEY);
        end
    endtask

    task automatic test_reset_mid_wait();
        startup(6);              // cycle 6: IF/ID = 0x8
        ifid_write     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        mem_lat        = 4;
        tick();                  // cycle 8: request 0x40 outstanding
        tests_run++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8) begin
            tests_failed++;
            $display("FAIL rst_pre: got v=%b pc=%h, expected 1 00000008", ifid_valid, ifid_pc);
        end
        pc_write = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_ir !== NOP || fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async: got v=%b pc=%h ir=%h mis=%b req=%b, expected 0 00000000 %h 0 0",
                     ifid_valid, ifid_pc, ifid_ir, fetch_misaligned, imem_req_valid, NOP);
        end
        tick();
        reset = 1'b1;
        tick();
        tick();                  // cycle 11: stale response for 0x40 arrives
        tests_run++;
        if (imem_resp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_stale_setup: got resp_valid=%b, expected 1", imem_resp_valid);
        end
        ifid_write = 1'b1;
        tick();
        tests_run++;
        if (ifid_valid !== 1'b0 || ifid_ir !== NOP || ifid_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_stale_ignored: got v=%b pc=%h ir=%h, expected 0 00000000 %h", ifid_valid, ifid_pc, ifid_ir, NOP);
        end
        pc_write = 1'b1;
        mem_lat  = 1;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL rst_first_req: got valid=%b addr=%h, expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        tick();
        tick();
        tests_run++;
        if (ifid_valid !== 1'b1 || ifid_pc !== RESET_PC || ifid_ir !== (RESET_PC ^ KEY)) begin
            tests_failed++;
            $display("FAIL rst_first_ifid: got v=%b pc=%h ir=%h, expected 1 %h %h", ifid_valid, ifid_pc, ifid_ir, RESET_PC, RESET_PC ^ KEY);
        end
    endtask

    // Random run. The model tracks the address the next fetch must use and a
    // queue of fetched addresses not yet consumed. A redirect empties the
    // queue; each IF/ID delivery must come from the queue in order, skipping
    // entries only when a flush has intervened.
    task automatic test_random();
        logic [31:0] exp_addr;
        logic [31:0] q[$];
        bit          flushed;
        bit          p_redirect, p_write, p_flush;
        logic [31:0] p_target;
        logic        h_valid;
        logic [31:0] h_pc, h_ir;
        int          idx;
        int          drain_deliveries;

        startup(0);
        exp_addr         = RESET_PC;
        flushed          = 1'b0;
        drain_deliveries = 0;
        for (int i = 0; i < 2030; i++) begin
            if (i < 2000) begin
                pc_write       = ($urandom_range(0, 9) < 8);
                ifid_write     = ($urandom_range(0, 9) < 7);
                flush          = ($urandom_range(0, 9) == 0);
                imem_req_ready = ($urandom_range(0, 3) != 0);
                redirect_valid = ($urandom_range(0, 11) == 0);
                redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                             : 32'($urandom_range(0, 4095));
                mem_lat        = $urandom_range(1, 3);
            end else begin
                pc_write       = 1'b1;
                ifid_write     = 1'b1;
                flush          = 1'b0;
                imem_req_ready = 1'b1;
                redirect_valid = 1'b0;
            end
            #1;
            if (imem_req_valid === 1'b1 && (redirect_valid || !pc_write)) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rnd_req_gate cyc%0d: got req_valid=1 with redirect=%b pc_write=%b, expected 0",
                         i, redirect_valid, pc_write);
            end
            p_redirect = redirect_valid;
            p_target   = redirect_pc;
            p_write    = ifid_write;
            p_flush    = flush;
            h_valid    = ifid_valid;
            h_pc       = ifid_pc;
            h_ir       = ifid_ir;
            tick();

            tests_run++;
            if (proto_err) begin
                tests_failed++;
                $display("FAIL rnd_outstanding cyc%0d: got second request while one outstanding, expected at most one", i);
                proto_err = 1'b0;
            end
            if (acc) begin
                tests_run++;
                if (acc_addr !== exp_addr) begin
                    tests_failed++;
                    $display("FAIL rnd_req_addr cyc%0d: got %h, expected %h", i, acc_addr, exp_addr);
                end
                exp_addr = exp_addr + 32'd4;
                q.push_back(acc_addr);
            end
            if (p_redirect) begin
                exp_addr = {p_target[31:2], 2'b00};
                q.delete();
            end
            tests_run++;
            if (fetch_misaligned !== (p_redirect && p_target[1:0] != 2'b00)) begin
                tests_failed++;
                $display("FAIL rnd_misaligned cyc%0d: got %b, expected %b", i, fetch_misaligned, p_redirect && p_target[1:0] != 2'b00);
            end

            tests_run++;
            if (p_flush) begin
                flushed = 1'b1;
                if (ifid_valid !== 1'b0 || ifid_ir !== NOP || ifid_pc !== h_pc) begin
                    tests_failed++;
                    $display("FAIL rnd_flush cyc%0d: got v=%b pc=%h ir=%h, expected 0 %h %h", i, ifid_valid, ifid_pc, ifid_ir, h_pc, NOP);
                end
            end else if (p_write) begin
                if (ifid_valid === 1'b1) begin
                    idx = -1;
                    foreach (q[j]) if (idx < 0 && q[j] === ifid_pc) idx = j;
                    if (idx < 0 || (idx > 0 && !flushed) || ifid_ir !== (ifid_pc ^ KEY)) begin
                        tests_failed++;
                        $display("FAIL rnd_delivery cyc%0d: got pc=%h ir=%h at queue index %0d (queue size %0d), expected queue head with ir=%h",
                                 i, ifid_pc, ifid_ir, idx, q.size(), ifid_pc ^ KEY);
                    end
                    for (int j = 0; j <= idx; j++) void'(q.pop_front());
                    flushed = 1'b0;
                    if (i >= 2000) drain_deliveries++;
                end else if (ifid_ir !== NOP) begin
                    tests_failed++;
                    $display("FAIL rnd_bubble cyc%0d: got ir=%h, expected %h", i, ifid_ir, NOP);
                end
            end else begin
                if (ifid_valid !== h_valid || ifid_pc !== h_pc || ifid_ir !== h_ir) begin
                    tests_failed++;
                    $display("FAIL rnd_hold cyc%0d: got v=%b pc=%h ir=%h, expected %b %h %h",
                             i, ifid_valid, ifid_pc, ifid_ir, h_valid, h_pc, h_ir);
                end
            end
        end
        tests_run++;
        if (drain_deliveries < 5) begin
            tests_failed++;
            $display("FAIL rnd_drain: got %0d deliveries in 30 free-running cycles, expected at least 5", drain_deliveries);
        end
    endtask

    initial begin
        reset          = 1'b0;
        pc_write       = 1'b0;
        ifid_write     = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        mem_pend       = 1'b0;
        mem_lat        = 1;
        proto_err      = 1'b0;
        @(negedge clk);

        test_reset();
        test_sequential();
        test_hold_buffer();
        test_redirect_wait();
        test_misaligned();
        test_wrap_and_freeze();
        test_flush();
        test_reset_mid_wait();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
